fir_out_checker: RTL and testbench
==================================

Name: fir_out_checker

Overview:
- Synthesizable response checker that sits on the output side of the 3-tap FIR.
- Samples the FIR input x and coefficients, and computes the golden Q4.4 output in hardware.
- Aligns the golden value to the FIR's pipeline latency and compares it with the FIR's y every clock.
- Reports mismatch count, first failing sample index and a pass/done verdict for on-board or simulation self-check.

Parameters:
- LATENCY, 1, clocks from x being sampled to the matching y_dut being valid (1..15).
- N_SAMPLES, 11, number of consecutive input samples checked per run (1..65535).
- SATURATE, 0, 0 = golden output wraps (takes bits [11:4]); 1 = golden output clamps to [-128,127].

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE.
- a  in  8  signed Q4.4 coefficient for x[n].
- b  in  8  signed Q4.4 coefficient for x[n-1].
- c  in  8  signed Q4.4 coefficient for x[n-2].
- x  in  8  signed Q4.4 sample, same signal driven into the FIR.
- y_dut  in  8  signed Q4.4 FIR output under check.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until next start or rst.
- pass  out  1  valid when done=1; high iff err_count==0.
- mismatch  out  1  one-cycle pulse on each compare failure.
- err_count  out  16  number of mismatches this run; saturates at 0xFFFF.
- first_err_idx  out  16  sample index of first mismatch; 0xFFFF if none.
- exp_y  out  8  golden value used in the current compare cycle.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - busy, done, pass, mismatch, err_count and exp_y all go to 0.
  - first_err_idx goes to 0xFFFF.
  - x history and the latency pipe are cleared.
  - rst overrides start and aborts any run in progress.
- FSM states are IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 clears counters, x history (x[n-1]=x[n-2]=0) and latency pipe; sets busy=1; next state RUN.
  - RUN: samples x each cycle with index k=0..N_SAMPLES-1. After sample N_SAMPLES-1, next state DRAIN.
  - DRAIN: continues comparing until the last sample's compare has completed (LATENCY cycles after its capture), then next state DONE.
  - DONE: busy=0, done=1, pass=(err_count==0). start=1 begins a new run exactly as from IDLE.
  - start is ignored in RUN and DRAIN.
- Golden arithmetic:
  - Products a*x[n], b*x[n-1], c*x[n-2] are 16-bit signed (Q8.8).
  - Sum is 18-bit signed.
  - Result is the sum arithmetically shifted right by 4 (truncation toward -inf).
  - SATURATE=0: exp = sum[11:4].
  - SATURATE=1: exp = clamp(sum>>>4, -128, 127).
- Alignment:
  - The golden value for sample k is produced in the cycle x[k] is sampled.
  - It is delayed through a LATENCY-deep register pipe with a valid bit.
  - It is compared with y_dut at the posedge LATENCY cycles after x[k] was sampled.
  - Compares occur only when the pipe valid bit is set; there are no compares before sample 0 arrives or after sample N_SAMPLES-1.
- Mismatch handling:
  - A mismatch pulses mismatch for one cycle in the cycle following the compare edge.
  - It increments err_count (saturating at 0xFFFF).
  - If this is the first mismatch of the run, first_err_idx is loaded with k.
- exp_y is registered alongside mismatch, so it shows the value compared in the preceding edge's compare.
- Total run length from start to done=1 is N_SAMPLES+LATENCY+1 cycles.
- Coefficients are sampled every cycle; changing them mid-run is legal and affects subsequent golden values only.

Test Plan:
- Reference DUT, no errors:
  - Stimulus: a=0x08 (0.5), b=0xE8 (-1.5), c=0x20 (2.0); x=-5..5 in Q4.4 (0xB0,0xC0,...,0x50); LATENCY=1; y_dut from a correct FIR model.
  - Required: exp_y sequence starts 0xD8, 0x58, 0xA8; done=1 at cycle 13 after start; pass=1; err_count=0; first_err_idx=0xFFFF.
- Single injected error:
  - Stimulus: same as above, with y_dut for sample 3 XOR 0x01.
  - Required: exactly one mismatch pulse; err_count=1; first_err_idx=3; pass=0.
- Overflow:
  - Stimulus: a=b=c=x=0x7F held for the run; full sum 48387, >>4 gives 0xBD0.
  - Required: SATURATE=0 → steady-state exp_y=0xD0; SATURATE=1 → 0x7F.
  - Required: a DUT output of the other value flags a mismatch every steady-state sample.
- Latency misalignment:
  - Stimulus: checker at LATENCY=2, correct FIR with latency 1, ramp x as above.
  - Required: err_count>0; first_err_idx equals the first sample where consecutive golden outputs differ.
- Control boundaries:
  - Stimulus: start pulsed again during RUN, then rst pulsed in DRAIN.
  - Required: second start ignored (err_count not cleared); after rst all outputs at reset values and busy=0.
  - Required: a new start then completes a clean run with pass=1.

Source files
------------

// File: rtl/fir_out_checker.sv
// rtl/fir_out_checker.sv - golden-model response checker for the 3-tap Q4.4 FIR output
module fir_out_checker #(
    parameter int LATENCY   = 1,
    parameter int N_SAMPLES = 11,
    parameter bit SATURATE  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  c,
    input  logic [7:0]  x,
    input  logic [7:0]  y_dut,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        mismatch,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx,
    output logic [7:0]  exp_y
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [7:0]         x1, x2;
    logic [15:0]        k;
    logic [15:0]        cmp_idx;
    logic [7:0]         pipe_d [LATENCY];
    logic [LATENCY-1:0] pipe_v;

    logic signed [15:0] pa, pb, pc;
    logic signed [17:0] sum;
    logic signed [13:0] sh;
    logic [7:0]         gold;

    always_comb begin
        pa  = $signed(a) * $signed(x);
        pb  = $signed(b) * $signed(x1);
        pc  = $signed(c) * $signed(x2);
        sum = {{2{pa[15]}}, pa} + {{2{pb[15]}}, pb} + {{2{pc[15]}}, pc};
        sh  = sum[17:4];
        gold = sum[11:4];
        if (SATURATE) begin
            if (sh > 14'sd127)
                gold = 8'h7F;
            else if (sh < -14'sd128)
                gold = 8'h80;
            else
                gold = sh[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            mismatch      <= 1'b0;
            err_count     <= 16'd0;
            first_err_idx <= 16'hFFFF;
            exp_y         <= 8'd0;
            x1            <= 8'd0;
            x2            <= 8'd0;
            k             <= 16'd0;
            cmp_idx       <= 16'd0;
            pipe_v        <= '0;
            for (int i = 0; i < LATENCY; i++)
                pipe_d[i] <= 8'd0;
        end else begin
            mismatch <= 1'b0;

            // Golden values enter the pipe only while samples are being captured
            for (int i = LATENCY - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            pipe_v[0] <= (state == RUN);
            pipe_d[0] <= gold;

            if (pipe_v[LATENCY-1]) begin
                exp_y   <= pipe_d[LATENCY-1];
                cmp_idx <= cmp_idx + 16'd1;
                if (pipe_d[LATENCY-1] != y_dut) begin
                    mismatch <= 1'b1;
                    if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                    if (err_count == 16'd0)
                        first_err_idx <= cmp_idx;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= 16'd0;
                        first_err_idx <= 16'hFFFF;
                        x1            <= 8'd0;
                        x2            <= 8'd0;
                        k             <= 16'd0;
                        cmp_idx       <= 16'd0;
                        pipe_v        <= '0;
                    end
                end
                RUN: begin
                    x1 <= x;
                    x2 <= x1;
                    k  <= k + 16'd1;
                    if (k == 16'(N_SAMPLES - 1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pipe_v == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 16'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_out_checker.sv
// tb/tb_fir_out_checker.sv - randomized and directed self-check of fir_out_checker
module tb_fir_out_checker;

    localparam int N  = 11;
    localparam int NC = 18;

    logic clk = 1'b0;
    logic rst, start;
    logic [7:0] a, b, c, x, y_a, y_b;

    logic        busy [3], done [3], pass [3], mismatch [3];
    logic [15:0] err_count [3], first_err_idx [3];
    logic [7:0]  exp_y [3];

    always #5 clk = ~clk;

    fir_out_checker #(.LATENCY(1), .N_SAMPLES(N), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .x(x), .y_dut(y_a),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .mismatch(mismatch[0]),
        .err_count(err_count[0]), .first_err_idx(first_err_idx[0]), .exp_y(exp_y[0]));

    fir_out_checker #(.LATENCY(2), .N_SAMPLES(N), .SATURATE(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .x(x), .y_dut(y_a),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .mismatch(mismatch[1]),
        .err_count(err_count[1]), .first_err_idx(first_err_idx[1]), .exp_y(exp_y[1]));

    fir_out_checker #(.LATENCY(1), .N_SAMPLES(N), .SATURATE(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .x(x), .y_dut(y_b),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .mismatch(mismatch[2]),
        .err_count(err_count[2]), .first_err_idx(first_err_idx[2]), .exp_y(exp_y[2]));

    // Per-cycle stimulus; cycle 0 carries start, sample k is presented in cycle k+1
    logic [7:0] xs [32], ca [32], cb [32], cc [32], ya [32], yb [32];
    logic [7:0] eh0 [32], eh2 [32];
    int n_assert = 0, n_fail = 0;
    int cnt_mis [3], done_at [3];
    int lat [3] = '{1, 2, 1};
    bit sat [3] = '{1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] golden(input int k, input bit s);
        int x0, x1v, x2v, sum, q;
        x0  = $signed(xs[k+1]);
        x1v = (k >= 1) ? int'($signed(xs[k])) : 0;
        x2v = (k >= 2) ? int'($signed(xs[k-1])) : 0;
        sum = $signed(ca[k+1]) * x0 + $signed(cb[k+1]) * x1v + $signed(cc[k+1]) * x2v;
        q = sum >>> 4;
        if (s) begin
            if (q > 127) q = 127;
            if (q < -128) q = -128;
        end
        return q[7:0];
    endfunction

    // Reference FIR with one cycle of latency, wrapping output
    task automatic fir_fill();
        for (int cy = 0; cy < 32; cy++) begin
            ya[cy] = (cy >= 2 && cy < 30) ? golden(cy - 2, 1'b0) : 8'h00;
            yb[cy] = ya[cy];
        end
    endtask

    task automatic fill_ramp();
        for (int cy = 0; cy < 32; cy++) begin
            xs[cy] = (cy >= 1 && cy <= N) ? 8'(8'hB0 + 16 * (cy - 1)) : 8'h00;
            ca[cy] = 8'h08; cb[cy] = 8'hE8; cc[cy] = 8'h20;
        end
        fir_fill();
    endtask

    task automatic model(input int i, output int e, output int f);
        logic [7:0] yv;
        e = 0; f = 16'hFFFF;
        for (int k = 0; k < N; k++) begin
            yv = (i == 2) ? yb[k + 1 + lat[i]] : ya[k + 1 + lat[i]];
            if (golden(k, sat[i]) !== yv) begin
                if (e == 0) f = k;
                e++;
            end
        end
    endtask

    task automatic drive(input int cy, input bit st);
        start = st;
        x = xs[cy]; a = ca[cy]; b = cb[cy]; c = cc[cy];
        y_a = ya[cy]; y_b = yb[cy];
    endtask

    task automatic run_seq();
        for (int i = 0; i < 3; i++) begin cnt_mis[i] = 0; done_at[i] = -1; end
        for (int cy = 0; cy < NC; cy++) begin
            @(negedge clk);
            if (cy >= 1) begin
                for (int i = 0; i < 3; i++) begin
                    if (mismatch[i]) cnt_mis[i]++;
                    if (done[i] && done_at[i] < 0) done_at[i] = cy - 1;
                end
            end
            eh0[cy] = exp_y[0];
            eh2[cy] = exp_y[2];
            drive(cy, cy == 0);
        end
    endtask

    task automatic check_run(input string nm);
        int e, f;
        for (int i = 0; i < 3; i++) begin
            model(i, e, f);
            chk($sformatf("%s.u%0d.err_count", nm, i), err_count[i], e);
            chk($sformatf("%s.u%0d.first_err_idx", nm, i), first_err_idx[i], f);
            chk($sformatf("%s.u%0d.pulses", nm, i), cnt_mis[i], e);
            chk($sformatf("%s.u%0d.pass", nm, i), pass[i], e == 0);
            chk($sformatf("%s.u%0d.done", nm, i), done[i], 1);
            chk($sformatf("%s.u%0d.busy", nm, i), busy[i], 0);
            chk($sformatf("%s.u%0d.done_cycle", nm, i), done_at[i], N + lat[i] + 1);
        end
        for (int k = 0; k < N; k++)
            chk($sformatf("%s.u0.exp_y[%0d]", nm, k), eh0[k + 3], golden(k, 1'b0));
    endtask

    task automatic check_reset(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.u%0d.busy", nm, i), busy[i], 0);
            chk($sformatf("%s.u%0d.done", nm, i), done[i], 0);
            chk($sformatf("%s.u%0d.pass", nm, i), pass[i], 0);
            chk($sformatf("%s.u%0d.mismatch", nm, i), mismatch[i], 0);
            chk($sformatf("%s.u%0d.err_count", nm, i), err_count[i], 0);
            chk($sformatf("%s.u%0d.first_err_idx", nm, i), first_err_idx[i], 16'hFFFF);
            chk($sformatf("%s.u%0d.exp_y", nm, i), exp_y[i], 0);
        end
    endtask

    initial begin
        int e, f;
        rst = 1'b1; start = 1'b0;
        fill_ramp();
        drive(0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_reset("reset");

        // Clean ramp through a correct FIR
        fill_ramp();
        run_seq();
        check_run("ramp");
        chk("ramp.exp_y0", eh0[3], 8'hD8);
        chk("ramp.exp_y1", eh0[4], 8'h58);
        chk("ramp.exp_y2", eh0[5], 8'hA8);
        chk("ramp.u0.pass_const", pass[0], 1);
        chk("ramp.u1.misaligned_errs", err_count[1] > 0, 1);

        // Single flipped bit on sample 3
        fill_ramp();
        ya[3 + 2] = ya[3 + 2] ^ 8'h01;
        run_seq();
        check_run("inject");
        chk("inject.u0.first_const", first_err_idx[0], 3);
        chk("inject.u0.count_const", err_count[0], 1);

        // Overflow: wrapping checker sees a clamping DUT and vice versa
        for (int cy = 0; cy < 32; cy++) begin
            xs[cy] = 8'h7F; ca[cy] = 8'h7F; cb[cy] = 8'h7F; cc[cy] = 8'h7F;
        end
        for (int cy = 0; cy < 32; cy++) begin
            ya[cy] = (cy >= 2) ? golden(cy - 2, 1'b1) : 8'h00;
            yb[cy] = (cy >= 2) ? golden(cy - 2, 1'b0) : 8'h00;
        end
        run_seq();
        check_run("ovf");
        chk("ovf.u0.steady", eh0[8], 8'hD0);
        chk("ovf.u2.steady", eh2[8], 8'h7F);
        chk("ovf.u2.all_flag", err_count[2], N);

        // Randomized coefficients, samples and error injection
        for (int r = 0; r < 4; r++) begin
            for (int cy = 0; cy < 32; cy++) begin
                xs[cy] = 8'($urandom); ca[cy] = 8'($urandom);
                cb[cy] = 8'($urandom); cc[cy] = 8'($urandom);
            end
            fir_fill();
            for (int cy = 2; cy < 32; cy++)
                if ($urandom_range(0, 3) == 0) ya[cy] = ya[cy] ^ 8'($urandom_range(1, 255));
            run_seq();
            check_run($sformatf("rand%0d", r));
        end

        // Control: restart ignored in RUN, reset during DRAIN
        fill_ramp();
        ya[2] = ya[2] ^ 8'h10;
        for (int cy = 0; cy < 14; cy++) begin
            @(negedge clk);
            if (cy == 6) begin
                chk("ctl.err_kept", err_count[0], 1);
                chk("ctl.busy_run", busy[0], 1);
            end
            if (cy == 12) chk("ctl.busy_drain", busy[0], 1);
            if (cy == 13) check_reset("ctl.rst");
            drive(cy, cy == 0 || cy == 4);
            rst = (cy == 12);
        end
        @(negedge clk);
        rst = 1'b0;
        check_reset("ctl.rst_hold");
        fill_ramp();
        run_seq();
        check_run("ctl.clean");
        model(0, e, f);
        chk("ctl.clean.pass", pass[0] && (e == 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
